// File: rtl/ad9833_pkg.sv
// Shared encodings for the AD9833 sweep sequencer: word prefixes, control
// bit positions, waveform modes and FSM state types.
package ad9833_pkg;

    localparam logic [15:0] PFX_CTRL   = 16'h0000;
    localparam logic [15:0] PFX_FREQ0  = 16'h4000;
    localparam logic [15:0] PFX_FREQ1  = 16'h8000;
    localparam logic [15:0] PFX_PHASE0 = 16'hC000;

    localparam int B28_BIT     = 13;
    localparam int FSEL_BIT    = 11;
    localparam int RESET_BIT   = 8;
    localparam int OPBITEN_BIT = 5;
    localparam int DIV2_BIT    = 3;
    localparam int MODE_BIT    = 1;

    localparam logic [1:0] MODE_SINE = 2'b00;
    localparam logic [1:0] MODE_TRI  = 2'b01;
    localparam logic [1:0] MODE_SQ   = 2'b10;
    localparam logic [1:0] MODE_SQ2  = 2'b11;

    typedef enum logic [2:0] {
        SW_IDLE,
        SW_INIT,
        SW_DWELL,
        SW_STEP,
        SW_ABORT,
        SW_DONE
    } sweep_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_t;

    function automatic logic [15:0] ctrl_word(
        input logic [1:0] mode,
        input logic       fsel,
        input logic       rst
    );
        logic [15:0] w;
        w              = PFX_CTRL;
        w[B28_BIT]     = 1'b1;
        w[FSEL_BIT]    = fsel;
        w[RESET_BIT]   = rst;
        case (mode)
            MODE_TRI: w[MODE_BIT] = 1'b1;
            MODE_SQ: begin
                w[OPBITEN_BIT] = 1'b1;
                w[DIV2_BIT]    = 1'b1;
            end
            MODE_SQ2: w[OPBITEN_BIT] = 1'b1;
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ad9833_word_tx.sv
// Single-word handshake toward ad9833_engine: strobe, wait for busy to
// rise (with timeout), then wait for busy to fall.
module ad9833_word_tx
    import ad9833_pkg::*;
#(
    parameter int BUSY_TO = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] word,
    input  logic        bus_busy,
    output logic        start_pluse,
    output logic [15:0] cfg_data,
    output logic        done,
    output logic        timeout
);

    localparam int CW = $clog2(BUSY_TO + 1);

    tx_state_t       state;
    tx_state_t       state_d;
    logic [CW-1:0]   cnt;
    logic            issue;
    logic            to_hit;

    always_comb begin
        issue   = (state == TX_IDLE) && req && !bus_busy;
        to_hit  = (state == TX_WAIT_HI) && !bus_busy
                  && (cnt >= CW'(BUSY_TO - 1));
        done    = to_hit || ((state == TX_WAIT_LO) && !bus_busy);
        timeout = to_hit;
        state_d = state;
        case (state)
            TX_IDLE: begin
                if (issue) state_d = TX_WAIT_HI;
            end
            TX_WAIT_HI: begin
                if (bus_busy)    state_d = TX_WAIT_LO;
                else if (to_hit) state_d = TX_IDLE;
            end
            TX_WAIT_LO: begin
                if (!bus_busy) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_d;
    end

    // Data is latched at issue so it stays put for the whole transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_pluse <= 1'b0;
            cfg_data    <= 16'h0000;
            cnt         <= '0;
        end else begin
            start_pluse <= issue;
            if (issue) begin
                cfg_data <= word;
                cnt      <= '0;
            end else if (state == TX_WAIT_HI) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ad9833_sweep_seq.sv
// Linear frequency sweep word source for ad9833_engine.
// Build option: AD9833_PINGPONG_EN alternates FREQ1/FREQ0 with FSELECT switch.
module ad9833_sweep_seq
    import ad9833_pkg::*;
#(
    parameter int DWELL_W = 32,
    parameter int BUSY_TO = 1023
) (
    input  logic               sys_clk_i,
    input  logic               rst_n_i,
    input  logic               sweep_start_i,
    input  logic               sweep_abort_i,
    input  logic [27:0]        start_ftw_i,
    input  logic [27:0]        stop_ftw_i,
    input  logic [27:0]        step_ftw_i,
    input  logic [11:0]        phase_i,
    input  logic [1:0]         mode_i,
    input  logic [DWELL_W-1:0] dwell_cycles_i,
    output logic               start_pluse_o,
    output logic [15:0]        ad9833_cfg_data_o,
    input  logic               ad9833_bus_busy_i,
    output logic               sweep_busy_o,
    output logic               sweep_done_o,
    output logic [27:0]        cur_ftw_o,
    output logic               err_timeout_o
);

    localparam logic [2:0] INIT_LAST = 3'd4;
    localparam logic [2:0] INIT_MSB  = 3'd2;
    localparam logic [2:0] STEP_MSB  = 3'd1;

    sweep_state_t       state;
    sweep_state_t       state_d;
    logic [2:0]         wi;
    logic [27:0]        tgt_ftw;
    logic [27:0]        stop_r;
    logic [27:0]        step_r;
    logic [11:0]        phase_r;
    logic [1:0]         mode_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dir_up;
    logic               single_r;
    logic               fsel_r;
    logic               abort_pend;

    logic               w_sel;
    logic               accept;
    logic               abort_hit;
    logic               abort_req;
    logic               dwell_end;
    logic               at_end;
    logic [28:0]        sum;
    logic [28:0]        dif;
    logic [27:0]        next_ftw;
    logic [15:0]        pfx;
    logic [15:0]        word;
    logic               tx_req;
    logic               tx_done;
    logic               tx_to;

`ifdef AD9833_PINGPONG_EN
    localparam logic [2:0] STEP_LAST = 3'd2;
    assign w_sel = (state == SW_STEP) ? ~fsel_r : 1'b0;
`else
    localparam logic [2:0] STEP_LAST = 3'd1;
    assign w_sel = 1'b0;
`endif

    // 29-bit sums so a step past the 28-bit range still reads as overshoot.
    always_comb begin
        sum = {1'b0, tgt_ftw} + {1'b0, step_r};
        dif = {1'b0, tgt_ftw} - {1'b0, step_r};
        if (dir_up)
            next_ftw = (sum > {1'b0, stop_r}) ? stop_r : sum[27:0];
        else
            next_ftw = (dif[28] || (dif[27:0] < stop_r)) ? stop_r : dif[27:0];
    end

    always_comb begin
        pfx  = w_sel ? PFX_FREQ1 : PFX_FREQ0;
        word = ctrl_word(mode_r, fsel_r, 1'b1);
        unique case (1'b1)
            (state == SW_INIT): begin
                case (wi)
                    3'd0:    word = ctrl_word(mode_r, 1'b0, 1'b1);
                    3'd1:    word = pfx | {2'b00, tgt_ftw[13:0]};
                    3'd2:    word = pfx | {2'b00, tgt_ftw[27:14]};
                    3'd3:    word = PFX_PHASE0 | {4'h0, phase_r};
                    default: word = ctrl_word(mode_r, 1'b0, 1'b0);
                endcase
            end
            (state == SW_STEP): begin
                case (wi)
                    3'd0:    word = pfx | {2'b00, tgt_ftw[13:0]};
                    3'd1:    word = pfx | {2'b00, tgt_ftw[27:14]};
                    default: word = ctrl_word(mode_r, w_sel, 1'b0);
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        accept    = (state == SW_IDLE) && sweep_start_i;
        abort_hit = sweep_abort_i && ((state == SW_INIT)
                    || (state == SW_DWELL) || (state == SW_STEP));
        abort_req = abort_pend || abort_hit;
        dwell_end = (state == SW_DWELL)
                    && (dwell_cnt == dwell_r - DWELL_W'(1));
        at_end    = single_r || (tgt_ftw == stop_r);
        tx_req    = (state == SW_INIT) || (state == SW_STEP)
                    || (state == SW_ABORT);
        state_d   = state;
        case (state)
            SW_IDLE: begin
                if (sweep_start_i) state_d = SW_INIT;
            end
            SW_INIT: begin
                if (tx_done) begin
                    if (abort_req)             state_d = SW_ABORT;
                    else if (wi == INIT_LAST)  state_d = SW_DWELL;
                end
            end
            SW_DWELL: begin
                if (abort_req)      state_d = SW_ABORT;
                else if (dwell_end) state_d = at_end ? SW_DONE : SW_STEP;
            end
            SW_STEP: begin
                if (tx_done) begin
                    if (abort_req)             state_d = SW_ABORT;
                    else if (wi == STEP_LAST)  state_d = SW_DWELL;
                end
            end
            SW_ABORT: begin
                if (tx_done) state_d = SW_DONE;
            end
            default: state_d = SW_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) state <= SW_IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            wi            <= 3'd0;
            tgt_ftw       <= '0;
            stop_r        <= '0;
            step_r        <= '0;
            phase_r       <= '0;
            mode_r        <= '0;
            dwell_r       <= '0;
            dwell_cnt     <= '0;
            dir_up        <= 1'b0;
            single_r      <= 1'b0;
            fsel_r        <= 1'b0;
            abort_pend    <= 1'b0;
            cur_ftw_o     <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            if (accept) begin
                tgt_ftw       <= start_ftw_i;
                stop_r        <= stop_ftw_i;
                step_r        <= step_ftw_i;
                phase_r       <= phase_i;
                mode_r        <= mode_i;
                dwell_r       <= (dwell_cycles_i == '0) ? DWELL_W'(1)
                                                        : dwell_cycles_i;
                dir_up        <= (stop_ftw_i >= start_ftw_i);
                single_r      <= (start_ftw_i == stop_ftw_i)
                                 || (step_ftw_i == '0);
                fsel_r        <= 1'b0;
                abort_pend    <= 1'b0;
                err_timeout_o <= 1'b0;
            end
            if (abort_hit)          abort_pend    <= 1'b1;
            if (state == SW_DONE)   abort_pend    <= 1'b0;
            if (tx_to)              err_timeout_o <= 1'b1;
            if (tx_done) begin
                wi <= wi + 3'd1;
                if (((state == SW_INIT) && (wi == INIT_MSB))
                    || ((state == SW_STEP) && (wi == STEP_MSB)))
                    cur_ftw_o <= tgt_ftw;
                if ((state == SW_STEP) && (wi == STEP_LAST))
                    fsel_r <= w_sel;
            end
            if (state_d != state) wi <= 3'd0;
            if (state == SW_DWELL) dwell_cnt <= dwell_cnt + DWELL_W'(1);
            else                   dwell_cnt <= '0;
            if (dwell_end && !at_end) tgt_ftw <= next_ftw;
        end
    end

    assign sweep_busy_o = (state != SW_IDLE);
    assign sweep_done_o = (state == SW_DONE);

    ad9833_word_tx #(
        .BUSY_TO (BUSY_TO)
    ) u_tx (
        .clk         (sys_clk_i),
        .rst_n       (rst_n_i),
        .req         (tx_req),
        .word        (word),
        .bus_busy    (ad9833_bus_busy_i),
        .start_pluse (start_pluse_o),
        .cfg_data    (ad9833_cfg_data_o),
        .done        (tx_done),
        .timeout     (tx_to)
    );

endmodule

// File: tb/tb_ad9833_sweep_seq.sv
// Directed bench for ad9833_sweep_seq with a behavioural engine busy model.
// Expected words follow the AD9833_PINGPONG_EN setting of the build.
module tb_ad9833_sweep_seq;

    localparam int TO = 20;

    typedef struct {
        logic [27:0] start;
        logic [27:0] stop;
        logic [27:0] step;
        logic [11:0] phase;
        logic [1:0]  mode;
        int          dwell;
        int          nw;
        logic [15:0] w[16];
        logic [27:0] fin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sweep_start = 1'b0;
    logic        sweep_abort = 1'b0;
    logic [27:0] start_ftw = '0;
    logic [27:0] stop_ftw = '0;
    logic [27:0] step_ftw = '0;
    logic [11:0] phase = '0;
    logic [1:0]  mode = '0;
    logic [31:0] dwell = '0;
    logic        start_pluse;
    logic [15:0] cfg_data;
    logic        eng_busy;
    logic        sweep_busy;
    logic        sweep_done;
    logic [27:0] cur_ftw;
    logic        err_to;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] words[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          strobe_cyc = 0;
    int          done_cyc = 0;
    int          eng_cnt = 0;
    bit          dead = 1'b0;
    vec_t        vt[5];

    always #5 clk = ~clk;

    ad9833_sweep_seq #(
        .DWELL_W (32),
        .BUSY_TO (TO)
    ) dut (
        .sys_clk_i         (clk),
        .rst_n_i           (rst_n),
        .sweep_start_i     (sweep_start),
        .sweep_abort_i     (sweep_abort),
        .start_ftw_i       (start_ftw),
        .stop_ftw_i        (stop_ftw),
        .step_ftw_i        (step_ftw),
        .phase_i           (phase),
        .mode_i            (mode),
        .dwell_cycles_i    (dwell),
        .start_pluse_o     (start_pluse),
        .ad9833_cfg_data_o (cfg_data),
        .ad9833_bus_busy_i (eng_busy),
        .sweep_busy_o      (sweep_busy),
        .sweep_done_o      (sweep_done),
        .cur_ftw_o         (cur_ftw),
        .err_timeout_o     (err_to)
    );

    assign eng_busy = (eng_cnt != 0) && !dead;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            eng_cnt <= 0;
        end else if (start_pluse) begin
            words.push_back(cfg_data);
            strobe_cyc <= cyc;
            eng_cnt <= 5;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (sweep_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        start_ftw = v.start;
        stop_ftw  = v.stop;
        step_ftw  = v.step;
        phase     = v.phase;
        mode      = v.mode;
        dwell     = 32'(v.dwell);
    endtask

    task automatic pulse(input bit s, input bit a);
        @(negedge clk);
        sweep_start = s;
        sweep_abort = a;
        @(negedge clk);
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL wait_done: no sweep_done within %0d cycles", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (words.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (words.size() < target) begin
            errors++;
            $display("FAIL wait_words: got %0d words, needed %0d",
                     words.size(), target);
        end
    endtask

    function automatic logic [15:0] word_at(input int idx);
        if (idx < words.size()) return words[idx];
        return 16'hxxxx;
    endfunction

    initial begin
        int base;
        int d0;
        int eff;
        vt[0] = '{28'h100, 28'h300, 28'h100, 12'h000, 2'b00, 50, 0,
                  '{default: 16'h0}, 28'h300};
        vt[1] = '{28'h300, 28'h0F0, 28'h100, 12'h000, 2'b00, 50, 0,
                  '{default: 16'h0}, 28'h0F0};
        vt[2] = '{28'h0FFFFF00, 28'h0FFFFFFF, 28'h200, 12'h000, 2'b00, 30, 0,
                  '{default: 16'h0}, 28'h0FFFFFFF};
        vt[3] = '{28'h1234, 28'h5000, 28'h0, 12'h123, 2'b10, 0, 5,
                  '{0: 16'h2128, 1: 16'h5234, 2: 16'h4000, 3: 16'hC123,
                    4: 16'h2028, default: 16'h0}, 28'h1234};
        vt[4] = '{28'h2345678, 28'h2345678, 28'h10, 12'hFFF, 2'b01, 7, 5,
                  '{0: 16'h2102, 1: 16'h5678, 2: 16'h48D1, 3: 16'hCFFF,
                    4: 16'h2002, default: 16'h0}, 28'h2345678};
`ifdef AD9833_PINGPONG_EN
        vt[0].nw = 11;
        vt[0].w  = '{0: 16'h2100, 1: 16'h4100, 2: 16'h4000, 3: 16'hC000,
                     4: 16'h2000, 5: 16'h8200, 6: 16'h8000, 7: 16'h2800,
                     8: 16'h4300, 9: 16'h4000, 10: 16'h2000, default: 16'h0};
        vt[1].nw = 14;
        vt[1].w  = '{0: 16'h2100, 1: 16'h4300, 2: 16'h4000, 3: 16'hC000,
                     4: 16'h2000, 5: 16'h8200, 6: 16'h8000, 7: 16'h2800,
                     8: 16'h4100, 9: 16'h4000, 10: 16'h2000, 11: 16'h80F0,
                     12: 16'h8000, 13: 16'h2800, default: 16'h0};
        vt[2].nw = 8;
        vt[2].w  = '{0: 16'h2100, 1: 16'h7F00, 2: 16'h7FFF, 3: 16'hC000,
                     4: 16'h2000, 5: 16'hBFFF, 6: 16'hBFFF, 7: 16'h2800,
                     default: 16'h0};
`else
        vt[0].nw = 9;
        vt[0].w  = '{0: 16'h2100, 1: 16'h4100, 2: 16'h4000, 3: 16'hC000,
                     4: 16'h2000, 5: 16'h4200, 6: 16'h4000, 7: 16'h4300,
                     8: 16'h4000, default: 16'h0};
        vt[1].nw = 11;
        vt[1].w  = '{0: 16'h2100, 1: 16'h4300, 2: 16'h4000, 3: 16'hC000,
                     4: 16'h2000, 5: 16'h4200, 6: 16'h4000, 7: 16'h4100,
                     8: 16'h4000, 9: 16'h40F0, 10: 16'h4000, default: 16'h0};
        vt[2].nw = 7;
        vt[2].w  = '{0: 16'h2100, 1: 16'h7F00, 2: 16'h7FFF, 3: 16'hC000,
                     4: 16'h2000, 5: 16'h7FFF, 6: 16'h7FFF, default: 16'h0};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_strobe", 32'(start_pluse), 0);
        chk("rst_data", 32'(cfg_data), 0);
        chk("rst_busy", 32'(sweep_busy), 0);
        chk("rst_done", 32'(sweep_done), 0);
        chk("rst_cur", 32'(cur_ftw), 0);
        chk("rst_err", 32'(err_to), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven sweeps
        for (int k = 0; k < 5; k++) begin
            base = words.size();
            d0   = done_cnt;
            apply(vt[k]);
            pulse(1'b1, 1'b0);
            wait_done(d0, 20000);
            chk($sformatf("v%0d_nwords", k), 32'(words.size() - base),
                32'(vt[k].nw));
            for (int j = 0; j < vt[k].nw; j++)
                chk($sformatf("v%0d_w%0d", k, j), 32'(word_at(base + j)),
                    32'(vt[k].w[j]));
            chk($sformatf("v%0d_cur", k), 32'(cur_ftw), 32'(vt[k].fin));
            chk($sformatf("v%0d_ndone", k), 32'(done_cnt - d0), 1);
            chk($sformatf("v%0d_busy", k), 32'(sweep_busy), 0);
            chk($sformatf("v%0d_err", k), 32'(err_to), 0);
            eff = (vt[k].dwell == 0) ? 1 : vt[k].dwell;
            chk($sformatf("v%0d_dwell", k),
                32'((done_cyc - strobe_cyc >= eff)
                    && (done_cyc - strobe_cyc <= eff + 20)), 1);
        end

        // Abort during dwell of the second point
        base = words.size();
        d0   = done_cnt;
        apply(vt[0]);
        dwell = 32'd200;
        pulse(1'b1, 1'b0);
        for (int n = 0; n < 2000 && cur_ftw != 28'h200; n++) @(negedge clk);
        repeat (20) @(negedge clk);
        pulse(1'b0, 1'b1);
        wait_done(d0, 2000);
`ifdef AD9833_PINGPONG_EN
        chk("abd_nwords", 32'(words.size() - base), 9);
        chk("abd_last", 32'(word_at(base + 8)), 32'h2900);
`else
        chk("abd_nwords", 32'(words.size() - base), 8);
        chk("abd_last", 32'(word_at(base + 7)), 32'h2100);
`endif
        chk("abd_cur", 32'(cur_ftw), 32'h200);
        chk("abd_ndone", 32'(done_cnt - d0), 1);
        chk("abd_busy", 32'(sweep_busy), 0);

        // Abort while a step word is in flight
        base = words.size();
        d0   = done_cnt;
        apply(vt[0]);
        pulse(1'b1, 1'b0);
        wait_words(base + 6, 2000);
        sweep_abort = 1'b1;
        @(negedge clk);
        sweep_abort = 1'b0;
        wait_done(d0, 2000);
        chk("abf_nwords", 32'(words.size() - base), 7);
        chk("abf_last", 32'(word_at(base + 6)), 32'h2100);
        chk("abf_cur", 32'(cur_ftw), 32'h100);
        chk("abf_ndone", 32'(done_cnt - d0), 1);

        // Abort in idle is ignored
        base = words.size();
        d0   = done_cnt;
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("abi_busy", 32'(sweep_busy), 0);
        chk("abi_ndone", 32'(done_cnt - d0), 0);
        chk("abi_nwords", 32'(words.size() - base), 0);

        // Start and abort together in idle: start wins
        base = words.size();
        d0   = done_cnt;
        apply(vt[3]);
        pulse(1'b1, 1'b1);
        wait_done(d0, 2000);
        chk("sa_nwords", 32'(words.size() - base), 5);
        chk("sa_last", 32'(word_at(base + 4)), 32'h2028);

        // Engine never raises busy: timeout flagged, sweep still finishes
        base = words.size();
        d0   = done_cnt;
        dead = 1'b1;
        apply(vt[3]);
        pulse(1'b1, 1'b0);
        wait_done(d0, 2000);
        chk("to_err", 32'(err_to), 1);
        chk("to_nwords", 32'(words.size() - base), 5);
        chk("to_ndone", 32'(done_cnt - d0), 1);
        dead = 1'b0;
        d0 = done_cnt;
        apply(vt[4]);
        pulse(1'b1, 1'b0);
        chk("to_clear", 32'(err_to), 0);
        wait_done(d0, 2000);

        // Reset in the middle of a word
        apply(vt[0]);
        pulse(1'b1, 1'b0);
        for (int n = 0; n < 200 && !start_pluse; n++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_strobe", 32'(start_pluse), 0);
        chk("mrst_data", 32'(cfg_data), 0);
        chk("mrst_busy", 32'(sweep_busy), 0);
        chk("mrst_cur", 32'(cur_ftw), 0);
        chk("mrst_err", 32'(err_to), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
